serial_work_master: RTL and testbench

Controller-side endpoint of the worker serial link. It accepts one 512-bit work unit (midstate + data2) and transmits it as a 64-byte frame, leaving each worker's byte-shift deserializer with exactly the loaded words. It also reassembles the 4-byte golden-nonce words returned by workers. It sits on a controller FPGA or in a board-level test harness, between the work scheduler and the UART pins, and wraps the existing async_transmitter/async_receiver.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/async_receiver.sv | 63 ++++++
 rtl/async_transmitter.sv | 53 +++++
 rtl/serial_nonce_assembler.sv | 68 ++++++
 rtl/serial_work_master.sv | 134 +++++++++++++
 tb/tb_serial_work_master.sv | 319 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the worker serial link.
//   tx_state_t  : frame transmitter states
//   FRAME_BYTES : bytes per work frame (512-bit work unit)
//   NONCE_BYTES : bytes per returned golden-nonce word
package serial_pkg;

  localparam int WORK_W      = 512;
  localparam int FRAME_BYTES = WORK_W / 8;
  localparam int NONCE_BYTES = 4;
  localparam int NONCE_W     = NONCE_BYTES * 8;

  // Frame counter must hold the terminal value FRAME_BYTES itself.
  localparam int FRAME_CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int NONCE_CNT_W = $clog2(NONCE_BYTES);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_GAP,
    TX_WAIT,
    TX_DONE
  } tx_state_t;

endpackage

// File: rtl/async_receiver.sv
// 8N1 UART deserializer.
//   clk, rst_n     : clock, async active-low reset
//   RxD            : serial line, LSB first
//   RxD_data_ready : one-cycle pulse when a byte with a valid stop bit is in
//   RxD_data       : received byte, valid with RxD_data_ready
module async_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  logic              rx_s1, rx_s2;
  logic              active;
  logic [BAUD_W-1:0] baud;
  logic [3:0]        bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1          <= 1'b1;
      rx_s2          <= 1'b1;
      active         <= 1'b0;
      baud           <= '0;
      bit_idx        <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
    end else begin
      rx_s1          <= RxD;
      rx_s2          <= rx_s1;
      RxD_data_ready <= 1'b0;
      if (!active) begin
        // Falling edge: first sample lands mid start bit.
        if (!rx_s2) begin
          active  <= 1'b1;
          baud    <= HALF_LOAD;
          bit_idx <= 4'd0;
        end
      end else if (baud != '0) begin
        baud <= baud - 1'b1;
      end else begin
        baud <= BAUD_LOAD;
        if (bit_idx == 4'd0) begin
          if (rx_s2) active <= 1'b0;  // glitch, not a start bit
          else       bit_idx <= 4'd1;
        end else if (bit_idx == 4'd9) begin
          active         <= 1'b0;
          RxD_data_ready <= rx_s2;
        end else begin
          RxD_data <= {rx_s2, RxD_data[7:1]};
          bit_idx  <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/async_transmitter.sv
// 8N1 UART serializer.
//   clk, rst_n  : clock, async active-low reset (line forced idle-high)
//   TxD_start   : start a byte (ignored while busy)
//   TxD_data    : byte to send, sampled with TxD_start
//   TxD         : serial line, LSB first
//   TxD_busy    : high from the cycle after TxD_start until the stop bit ends
module async_transmitter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud;
  logic [3:0]        bits_left;
  logic [8:0]        shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TxD       <= 1'b1;
      TxD_busy  <= 1'b0;
      baud      <= '0;
      bits_left <= '0;
      shreg     <= '1;
    end else if (!TxD_busy) begin
      if (TxD_start) begin
        TxD       <= 1'b0;
        TxD_busy  <= 1'b1;
        baud      <= BAUD_LOAD;
        bits_left <= 4'd9;
        shreg     <= {1'b1, TxD_data};
      end
    end else if (baud != '0) begin
      baud <= baud - 1'b1;
    end else if (bits_left == 4'd0) begin
      // Stop bit has been on the line for a full bit period.
      TxD_busy <= 1'b0;
    end else begin
      TxD       <= shreg[0];
      shreg     <= {1'b1, shreg[8:1]};
      bits_left <= bits_left - 1'b1;
      baud      <= BAUD_LOAD;
    end
  end

endmodule

// File: rtl/serial_nonce_assembler.sv
// Packs received bytes MSB-first into golden-nonce words and drops a partial
// word when the link goes quiet.
//   byte_valid/byte_data : received byte strobe
//   nonce_valid          : one-cycle pulse, word complete
//   nonce                : last completed word, held until the next one
//   rx_resync            : one-cycle pulse, partial word discarded
module serial_nonce_assembler
  import serial_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               nonce_valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               rx_resync
);

  localparam int ACC_W = NONCE_W - 8;
  localparam int TMR_W = $clog2(IDLE_TIMEOUT);
  // Loaded on the byte's own edge, so one tick is already spent.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [NONCE_CNT_W-1:0] LAST_BYTE = NONCE_CNT_W'(NONCE_BYTES - 1);

  logic [ACC_W-1:0]       acc;
  logic [NONCE_CNT_W-1:0] byte_cnt;
  logic [TMR_W-1:0]       timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      byte_cnt    <= '0;
      timer       <= '0;
      nonce       <= '0;
      nonce_valid <= 1'b0;
      rx_resync   <= 1'b0;
    end else begin
      nonce_valid <= 1'b0;
      rx_resync   <= 1'b0;
      // A byte on the terminal-count cycle takes priority over the timeout.
      if (byte_valid) begin
        if (byte_cnt == LAST_BYTE) begin
          nonce       <= {acc, byte_data};
          nonce_valid <= 1'b1;
          acc         <= '0;
          byte_cnt    <= '0;
          timer       <= '0;
        end else begin
          acc      <= {acc[ACC_W-9:0], byte_data};
          byte_cnt <= byte_cnt + 1'b1;
          timer    <= TMR_LOAD;
        end
      end else if (byte_cnt != '0) begin
        if (timer == TMR_W'(1)) begin
          rx_resync <= 1'b1;
          acc       <= '0;
          byte_cnt  <= '0;
          timer     <= '0;
        end else begin
          timer <= timer - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_work_master.sv
// Controller-side endpoint of the worker serial link. Sends one 512-bit work
// unit as a 64-byte frame (midstate MSB first, data2 LSB last) and collects
// 4-byte golden-nonce words coming back. TX and RX run independently.
//   RxD / TxD              : serial from / to worker
//   work_valid/work_ready  : work handshake, ready only in TX_IDLE
//   midstate, data2        : work unit, sampled on accept
//   tx_busy                : frame in progress
//   nonce_valid, nonce     : completed nonce word strobe and value
//   rx_resync              : partial nonce word dropped after idle timeout
//
// state    | meaning
// TX_IDLE  | waiting for work, work_ready high
// TX_START | pulse serializer start with current top byte once it is free
// TX_GAP   | one cycle for serializer busy to rise
// TX_WAIT  | wait for byte to finish, then shift and count
// TX_DONE  | frame finished, one cycle before accepting new work
module serial_work_master
  import serial_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 50000,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RxD,
  output logic               TxD,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [255:0]       midstate,
  input  logic [255:0]       data2,
  output logic               tx_busy,
  output logic               nonce_valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               rx_resync
);

  localparam logic [FRAME_CNT_W-1:0] LAST_BYTE = FRAME_CNT_W'(FRAME_BYTES - 1);

  tx_state_t              state_q, state_d;
  logic [WORK_W-1:0]      sr_q;
  logic [FRAME_CNT_W-1:0] cnt_q;
  logic                   sr_load, sr_shift, cnt_clr, cnt_inc;
  logic                   ser_start, ser_busy;
  logic                   rx_ready;
  logic [7:0]             rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ser_start = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (work_valid) begin
          sr_load = 1'b1;
          cnt_clr = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (!ser_busy) begin
          ser_start = 1'b1;
          state_d   = TX_GAP;
        end
      end
      TX_GAP: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!ser_busy) begin
          sr_shift = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = (cnt_q == LAST_BYTE) ? TX_DONE : TX_START;
        end
      end
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (sr_load)       sr_q <= {midstate, data2};
      else if (sr_shift) sr_q <= {sr_q[WORK_W-9:0], 8'h00};
      if (cnt_clr)       cnt_q <= '0;
      else if (cnt_inc)  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign work_ready = (state_q == TX_IDLE);
  assign tx_busy    = ~work_ready;

  async_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .TxD_start(ser_start),
    .TxD_data (sr_q[WORK_W-1 -: 8]),
    .TxD      (TxD),
    .TxD_busy (ser_busy)
  );

  async_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxD           (RxD),
    .RxD_data_ready(rx_ready),
    .RxD_data      (rx_data)
  );

  serial_nonce_assembler #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_nonce (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (rx_ready),
    .byte_data  (rx_data),
    .nonce_valid(nonce_valid),
    .nonce      (nonce),
    .rx_resync  (rx_resync)
  );

endmodule

// File: tb/tb_serial_work_master.sv
module tb_serial_work_master;

  localparam int CPB      = 4;
  localparam int IT       = 200;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int FRAME_LO = 64 * (BYTE_CYC + 2);
  localparam int FRAME_HI = 64 * (BYTE_CYC + 3);
  localparam int BUDGET   = FRAME_HI + 200;

  logic         clk = 1'b0;
  logic         rst_n, RxD, TxD, work_valid, work_ready, tx_busy;
  logic         nonce_valid, rx_resync;
  logic [255:0] midstate, data2;
  logic [31:0]  nonce;

  int checks = 0, failures = 0;

  serial_work_master #(.IDLE_TIMEOUT(IT), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD), .TxD(TxD),
    .work_valid(work_valid), .work_ready(work_ready),
    .midstate(midstate), .data2(data2), .tx_busy(tx_busy),
    .nonce_valid(nonce_valid), .nonce(nonce), .rx_resync(rx_resync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_nonce_q[$];
  logic [7:0]  partial_q[$];
  logic [31:0] model_nonce = '0;
  int exp_resync = 0, seen_resync = 0, accepts = 0, nv_seen = 0, words_sent = 0;

  function automatic void model_rx_byte(input logic [7:0] b);
    partial_q.push_back(b);
    if (partial_q.size() == 4) begin
      exp_nonce_q.push_back({partial_q[0], partial_q[1], partial_q[2], partial_q[3]});
      words_sent++;
      partial_q.delete();
    end
  endfunction

  function automatic void model_silence(input int cycles);
    if (cycles >= IT + BYTE_CYC && partial_q.size() != 0) begin
      exp_resync++;
      partial_q.delete();
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  logic prev_nv = 1'b0, prev_rs = 1'b0;
  always @(negedge clk) begin
    logic [511:0] w;
    if (rst_n) begin
      chk("ready_vs_busy", work_ready, !tx_busy);
      if (work_valid && work_ready) begin
        w = {midstate, data2};
        for (int i = 0; i < 64; i++) exp_tx_q.push_back(w[511-8*i -: 8]);
        accepts++;
      end
      if (nonce_valid) begin
        nv_seen++;
        chk("nonce_pulse_single", prev_nv, 1'b0);
        if (exp_nonce_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL nonce_unexpected actual=%0h required=none", nonce);
        end else begin
          model_nonce = exp_nonce_q.pop_front();
          chk("nonce_word", nonce, model_nonce);
        end
      end else begin
        chk("nonce_hold", nonce, model_nonce);
      end
      if (rx_resync) begin
        seen_resync++;
        chk("resync_pulse_single", prev_rs, 1'b0);
      end
    end
    prev_nv = nonce_valid;
    prev_rs = rx_resync;
  end

  // ---------------- TxD line deserializer ----------------
  int m_state = 0, m_cnt = 0, frame_idx = 0;
  logic [7:0] m_byte;
  logic [7:0] rx_frame[64];
  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      m_state = 0;
      frame_idx = 0;
    end else if (m_state == 0) begin
      if (TxD == 1'b0) begin
        m_state = 1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == CPB / 2) begin
        chk("tx_start_bit", TxD, 1'b0);
      end else if (m_cnt > CPB / 2 && (m_cnt - CPB / 2) % CPB == 0) begin
        k = (m_cnt - CPB / 2) / CPB;
        if (k <= 8) begin
          m_byte[k-1] = TxD;
        end else begin
          chk("tx_stop_bit", TxD, 1'b1);
          if (exp_tx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected_byte actual=%0h required=none", m_byte);
          end else begin
            chk("tx_byte", m_byte, exp_tx_q.pop_front());
          end
          if (frame_idx < 64) rx_frame[frame_idx] = m_byte;
          frame_idx++;
          m_state = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_ready_high(input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!work_ready && cyc < BUDGET);
    if (!work_ready) begin
      checks++; failures++;
      $display("FAIL %s actual=busy required=ready after %0d cycles", nm, cyc);
    end
  endtask

  task automatic start_frame(input logic [255:0] ms, input logic [255:0] d2);
    int lat;
    @(posedge clk); #1;
    midstate = ms; data2 = d2; work_valid = 1'b1; frame_idx = 0;
    @(posedge clk); #1;
    work_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("ready_low_after_accept", work_ready, 1'b0);
    end while (TxD !== 1'b0 && lat < 20);
    chk("accept_to_txd_start", lat, 2);
  endtask

  task automatic run_frame(input logic [255:0] ms, input logic [255:0] d2);
    int cyc;
    start_frame(ms, d2);
    wait_ready_high("frame_done", cyc);
    chk("frame_cycles_in_range", (cyc >= FRAME_LO && cyc <= FRAME_HI), 1'b1);
    chk("frame_byte_count", frame_idx, 64);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    model_rx_byte(b);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      RxD = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (CPB) @(posedge clk);
      #1;
    end
    repeat (gap) @(posedge clk);
  endtask

  task automatic rx_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--) rx_byte(w[8*i +: 8], $urandom_range(gap_max, 0));
  endtask

  task automatic rx_silence(input int cycles);
    model_silence(cycles);
    repeat (cycles) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] ms, d2, ms_b, d2_b;
    int cyc;

    rst_n = 1'b0; RxD = 1'b1; work_valid = 1'b0; midstate = '0; data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_work_ready", work_ready, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_txd", TxD, 1'b1);
    chk("rst_nonce", nonce, 32'h0);
    chk("rst_nonce_valid", nonce_valid, 1'b0);
    chk("rst_rx_resync", rx_resync, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Counting-pattern frame: bytes 0x00..0x3F on the line.
    for (int i = 0; i < 32; i++) begin
      ms[255-8*i -: 8] = 8'(i);
      d2[255-8*i -: 8] = 8'(32 + i);
    end
    run_frame(ms, d2);
    for (int i = 0; i < 64; i++) chk("frame1_pattern", rx_frame[i], 64'(i));

    // work_valid held high with new data mid-frame.
    ms = rand256(); d2 = rand256(); ms_b = rand256(); d2_b = rand256();
    @(posedge clk); #1;
    midstate = ms; data2 = d2; work_valid = 1'b1; frame_idx = 0;
    @(posedge clk); #1;
    midstate = ms_b; data2 = d2_b;
    wait_ready_high("held_frame_a_done", cyc);
    chk("held_frame_a_bytes", frame_idx, 64);
    frame_idx = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_one_cycle_while_held", work_ready, 1'b0);
    work_valid = 1'b0;
    wait_ready_high("held_frame_b_done", cyc);
    chk("held_frame_b_bytes", frame_idx, 64);
    chk("accepts_after_held", accepts, 3);

    // Nonce reassembly.
    rx_word(32'hDEADBEEF, 3);
    rx_silence(50);
    chk("nonce_deadbeef", nonce, 32'hDEADBEEF);
    chk("no_resync_deadbeef", seen_resync, 0);

    rx_byte(8'h12, 3);
    rx_byte(8'h34, 3);
    rx_silence(2 * IT);
    chk("resync_after_timeout", seen_resync, 1);
    rx_word(32'hCAFEBABE, 3);
    rx_silence(50);
    chk("nonce_cafebabe", nonce, 32'hCAFEBABE);
    chk("resync_once", seen_resync, 1);

    // Full duplex: frame plus three nonce words.
    fork
      run_frame(rand256(), rand256());
      begin
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) rx_word($urandom, 8);
      end
    join
    rx_silence(50);
    chk("nonce_pulses_after_duplex", nv_seen, 5);

    // Reset in the middle of byte 20 (an all-zero byte, so TxD is low).
    ms = rand256();
    ms[95:88] = 8'h00;
    start_frame(ms, rand256());
    cyc = 0;
    while (frame_idx < 20 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_byte20", frame_idx, 20);
    repeat (3 * CPB) @(negedge clk);
    chk("txd_low_in_byte20", TxD, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_tx_q.delete();
    model_nonce = '0;
    @(negedge clk);
    chk("midrst_txd", TxD, 1'b1);
    chk("midrst_work_ready", work_ready, 1'b1);
    chk("midrst_tx_busy", tx_busy, 1'b0);
    chk("midrst_nonce", nonce, 32'h0);
    chk("midrst_nonce_valid", nonce_valid, 1'b0);
    chk("midrst_rx_resync", rx_resync, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(rand256(), rand256());

    // Random duplex traffic.
    for (int f = 0; f < 2; f++) begin
      fork
        run_frame(rand256(), rand256());
        begin
          repeat ($urandom_range(40, 5)) @(posedge clk);
          for (int i = 0; i < 2; i++) rx_word($urandom, 12);
        end
      join
    end
    rx_silence(50);

    chk("accept_count", accepts, 8);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
    chk("nonce_queue_drained", exp_nonce_q.size(), 0);
    chk("nonce_pulse_total", nv_seen, words_sent);
    chk("resync_total", seen_resync, exp_resync);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
